display_serializer: RTL and testbench

Parametrised successor to the fixed 4-digit BCD-to-7-segment serial sender. It converts NUM_DIGITS packed BCD digits plus per-digit decimal points into segment codes and captures the frame on a start handshake. The frame is shifted out on a generated serial clock with selectable bit order, then a latch strobe and a one-cycle done pulse are issued. It sits between the calculator datapath and an external shift-register/display driver chain.

---
 rtl/display_serializer_if.sv | 23 ++
 rtl/display_serializer.sv | 150 +++++++++++++++
 tb/tb_display_serializer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_serializer_if.sv
// rtl/display_serializer_if.sv - frame request and serial output bundle for display_serializer
interface display_serializer_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    start;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    busy;
    logic                    done;
    logic                    ser_data;
    logic                    ser_clk;
    logic                    ser_latch;

    modport master (
        output start, bcd_in, dp_in,
        input  busy, done, ser_data, ser_clk, ser_latch
    );

    modport slave (
        input  start, bcd_in, dp_in,
        output busy, done, ser_data, ser_clk, ser_latch
    );
endinterface

// File: rtl/display_serializer.sv
// rtl/display_serializer.sv - BCD to 7-segment frame encoder and serial sender (option: LEADING_ZERO_BLANK_EN)
module display_serializer #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 2,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    display_serializer_if.slave  bus
);
    localparam int B  = 8 * NUM_DIGITS;
    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(B) + 1;

    localparam logic [PW-1:0] PH_HIGH       = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_BIT_LAST   = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LATCH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_ONE        = PW'(1);
    localparam logic [BW-1:0] BIT_LAST      = BW'(B - 1);
    localparam logic [BW-1:0] BIT_ONE       = BW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [BW-1:0] bitc, bitc_n;
    logic [B-1:0]  shreg, shreg_n;
    logic [B-1:0]  frame_word;
    logic          busy_n, done_n, latch_n, sclk_n, sdata_n;

    // Segment bits {a,b,c,d,e,f,g,dp}; non-decimal nibbles show a dash.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_code = 8'hFC;
            4'd1:    seg_code = 8'h60;
            4'd2:    seg_code = 8'hDA;
            4'd3:    seg_code = 8'hF2;
            4'd4:    seg_code = 8'h66;
            4'd5:    seg_code = 8'hB6;
            4'd6:    seg_code = 8'hBE;
            4'd7:    seg_code = 8'hE0;
            4'd8:    seg_code = 8'hFE;
            4'd9:    seg_code = 8'hF6;
            default: seg_code = 8'h02;
        endcase
    endfunction

    // Encode all digits into the frame word that is captured on start.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic blanking;
        frame_word = '0;
        blanking   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (blanking && (i != 0) && (bus.bcd_in[4*i +: 4] == 4'd0) && !bus.dp_in[i]) begin
                frame_word[8*i +: 8] = 8'h00;
            end else begin
                blanking             = 1'b0;
                frame_word[8*i +: 8] = seg_code(bus.bcd_in[4*i +: 4]) | {7'd0, bus.dp_in[i]};
            end
        end
    end
`else
    always_comb begin
        frame_word = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            frame_word[8*i +: 8] = seg_code(bus.bcd_in[4*i +: 4]) | {7'd0, bus.dp_in[i]};
        end
    end
`endif

    // Next state, counters, shift register and the registered output values.
    always_comb begin
        state_n = state;
        phase_n = phase;
        bitc_n  = bitc;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_n = frame_word;
                    phase_n = '0;
                    bitc_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (phase == PH_BIT_LAST) begin
                    phase_n = '0;
                    if (bitc == BIT_LAST) begin
                        bitc_n  = '0;
                        shreg_n = '0;
                        state_n = LATCH;
                    end else begin
                        bitc_n  = bitc + BIT_ONE;
                        shreg_n = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                    end
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            LATCH: begin
                if (phase == PH_LATCH_LAST) begin
                    phase_n = '0;
                    state_n = DONE;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        busy_n  = (state_n == SHIFT) || (state_n == LATCH);
        done_n  = (state_n == DONE);
        latch_n = (state_n == LATCH);
        sclk_n  = (state_n == SHIFT) && (phase_n >= PH_HIGH);
        sdata_n = (state_n == SHIFT) && (LSB_FIRST ? shreg_n[0] : shreg_n[B-1]);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            phase         <= '0;
            bitc          <= '0;
            shreg         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ser_data  <= 1'b0;
            bus.ser_clk   <= 1'b0;
            bus.ser_latch <= 1'b0;
        end else begin
            state         <= state_n;
            phase         <= phase_n;
            bitc          <= bitc_n;
            shreg         <= shreg_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.ser_data  <= sdata_n;
            bus.ser_clk   <= sclk_n;
            bus.ser_latch <= latch_n;
        end
    end
endmodule

// File: tb/tb_display_serializer.sv
// tb/tb_display_serializer.sv - self-checking bench for display_serializer
module tb_display_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_serializer_if #(.NUM_DIGITS(4)) bus0 ();
    display_serializer_if #(.NUM_DIGITS(4)) bus1 ();
    display_serializer_if #(.NUM_DIGITS(1)) bus2 ();

    display_serializer #(.NUM_DIGITS(4), .CLK_DIV(2), .LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    display_serializer #(.NUM_DIGITS(4), .CLK_DIV(2), .LSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    display_serializer #(.NUM_DIGITS(1), .CLK_DIV(1), .LSB_FIRST(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    logic [2:0] m_busy, m_done, m_data, m_sclk, m_latch;
    assign m_busy  = {bus2.busy,      bus1.busy,      bus0.busy};
    assign m_done  = {bus2.done,      bus1.done,      bus0.done};
    assign m_data  = {bus2.ser_data,  bus1.ser_data,  bus0.ser_data};
    assign m_sclk  = {bus2.ser_clk,   bus1.ser_clk,   bus0.ser_clk};
    assign m_latch = {bus2.ser_latch, bus1.ser_latch, bus0.ser_latch};

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [31:0] exp_plain;
        logic [31:0] exp_blank;
    } vec_t;

    typedef struct {
        logic [3:0] bcd;
        logic       dp;
        logic [7:0] exp;
    } vec1_t;

    typedef struct {
        logic [31:0] frame;
        int          s;
    } exp_t;

    exp_t        sbq [3][$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bitc [3];
    logic [31:0] acc [3];
    int          lfirst [3];
    int          lcnt [3];
    int          busy_bad [3];
    logic        prev_sclk [3];
    int          stray [3];

    vec_t  vecs [8];
    vec1_t vecs1 [5];

    function automatic int dut_b(input int d);
        return (d == 2) ? 8 : 32;
    endfunction

    function automatic int dut_c(input int d);
        return (d == 2) ? 1 : 2;
    endfunction

    function automatic logic [31:0] pick(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
        return v.exp_blank;
`else
        return v.exp_plain;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic clear_mon(input int d);
        bitc[d]     = 0;
        acc[d]      = '0;
        lfirst[d]   = -1;
        lcnt[d]     = 0;
        busy_bad[d] = 0;
    endtask

    task automatic monitor();
        for (int d = 0; d < 3; d++) begin
            int   rel, b, c, pos;
            logic exp_busy;
            b = dut_b(d);
            c = dut_c(d);
            if (rst) begin
                clear_mon(d);
            end else if (sbq[d].size() == 0) begin
                if (m_busy[d] || m_done[d] || m_latch[d] || m_sclk[d] || m_data[d]) stray[d]++;
            end else begin
                rel      = cyc - sbq[d][0].s;
                exp_busy = (rel >= 1) && (rel <= 2*c*b + c);
                if (m_busy[d] !== exp_busy) busy_bad[d]++;
                if (!prev_sclk[d] && m_sclk[d]) begin
                    pos = (d == 1) ? (b - 1 - bitc[d]) : bitc[d];
                    if (bitc[d] < b) acc[d][pos] = m_data[d];
                    bitc[d]++;
                end
                if (m_latch[d]) begin
                    if (lcnt[d] == 0) lfirst[d] = rel;
                    lcnt[d]++;
                end
                if (m_done[d]) begin
                    chk($sformatf("d%0d_frame", d), acc[d], sbq[d][0].frame);
                    chk($sformatf("d%0d_bit_count", d), bitc[d], b);
                    chk($sformatf("d%0d_latch_start", d), lfirst[d], 2*c*b + 1);
                    chk($sformatf("d%0d_latch_len", d), lcnt[d], c);
                    chk($sformatf("d%0d_done_cycle", d), rel, 2*c*b + c + 1);
                    chk($sformatf("d%0d_busy_window", d), busy_bad[d], 0);
                    void'(sbq[d].pop_front());
                    clear_mon(d);
                end
            end
            prev_sclk[d] = m_sclk[d];
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic start01(input logic [15:0] bcd, input logic [3:0] dp, input logic [31:0] exp);
        exp_t e;
        bus0.bcd_in = bcd; bus0.dp_in = dp; bus0.start = 1'b1;
        bus1.bcd_in = bcd; bus1.dp_in = dp; bus1.start = 1'b1;
        e.frame = exp;
        e.s     = cyc;
        sbq[0].push_back(e);
        sbq[1].push_back(e);
        tick();
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (m_done[d]) begin
                found = 1'b1;
                break;
            end
        end
        chk($sformatf("d%0d_done_seen", d), found, 1'b1);
    endtask

    initial begin
        int   s0, q;
        exp_t e;

        vecs[0] = '{16'h1234, 4'b0000, 32'h60DAF266, 32'h60DAF266};
        vecs[1] = '{16'h9A07, 4'b0010, 32'hF602FDE0, 32'hF602FDE0};
        vecs[2] = '{16'h0005, 4'b0000, 32'hFCFCFCB6, 32'h000000B6};
        vecs[3] = '{16'h0000, 4'b0100, 32'hFCFDFCFC, 32'h00FDFCFC};
        vecs[4] = '{16'h8765, 4'b1111, 32'hFFE1BFB7, 32'hFFE1BFB7};
        vecs[5] = '{16'hFEDC, 4'b0000, 32'h02020202, 32'h02020202};
        vecs[6] = '{16'h0000, 4'b0000, 32'hFCFCFCFC, 32'h000000FC};
        vecs[7] = '{16'h0109, 4'b0000, 32'hFC60FCF6, 32'h0060FCF6};

        vecs1[0] = '{4'h8, 1'b1, 8'hFF};
        vecs1[1] = '{4'h0, 1'b0, 8'hFC};
        vecs1[2] = '{4'hB, 1'b0, 8'h02};
        vecs1[3] = '{4'h7, 1'b1, 8'hE1};
        vecs1[4] = '{4'h3, 1'b0, 8'hF2};

        for (int d = 0; d < 3; d++) begin
            clear_mon(d);
            prev_sclk[d] = 1'b0;
            stray[d]     = 0;
        end
        bus0.start = 1'b0; bus0.bcd_in = '0; bus0.dp_in = '0;
        bus1.start = 1'b0; bus1.bcd_in = '0; bus1.dp_in = '0;
        bus2.start = 1'b0; bus2.bcd_in = '0; bus2.dp_in = '0;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {m_busy, m_done, m_data, m_sclk, m_latch}, 15'd0);
        rst = 1'b0;
        tick();

        // Table vectors, each start issued the cycle after the previous done.
        for (int i = 0; i < 8; i++) begin
            start01(vecs[i].bcd, vecs[i].dp, pick(vecs[i]));
            wait_done(0, 400);
            tick();
        end

        // Inputs changed mid-frame and stray starts (including the done cycle) are ignored.
        s0 = cyc;
        start01(16'h1234, 4'b0000, 32'h60DAF266);
        for (int k = 0; k < 140; k++) begin
            int r;
            r = cyc - s0;
            if (r == 5) begin
                bus0.bcd_in = 16'h9999;
                bus1.bcd_in = 16'h9999;
            end
            bus0.start = (r == 10) || (r == 129) || (r == 131);
            bus1.start = bus0.start;
            tick();
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        chk("disturb_idle_busy", {bus1.busy, bus0.busy}, 2'b00);
        chk("disturb_queue_empty", sbq[0].size() + sbq[1].size(), 0);
        start01(16'h9999, 4'b0000, 32'hF6F6F6F6);
        wait_done(0, 400);
        tick();

        // Reset mid-frame aborts without latch or done.
        s0 = cyc;
        start01(16'h8765, 4'b1111, 32'hFFE1BFB7);
        while ((cyc - s0) < 40) tick();
        rst = 1'b1;
        tick();
        chk("rst_abort_outputs", {bus0.busy, bus0.done, bus0.ser_data, bus0.ser_clk, bus0.ser_latch,
                                  bus1.busy, bus1.done, bus1.ser_data, bus1.ser_clk, bus1.ser_latch}, 10'd0);
        rst = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        q = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if ((m_latch[1:0] != 2'b00) || (m_done[1:0] != 2'b00)) q++;
        end
        chk("rst_no_latch_done", q, 0);
        start01(16'h1234, 4'b0000, 32'h60DAF266);
        wait_done(0, 400);
        tick();

        // Single digit, CLK_DIV=1.
        for (int i = 0; i < 5; i++) begin
            bus2.bcd_in = vecs1[i].bcd;
            bus2.dp_in  = vecs1[i].dp;
            bus2.start  = 1'b1;
            e.frame = {24'd0, vecs1[i].exp};
            e.s     = cyc;
            sbq[2].push_back(e);
            tick();
            bus2.start = 1'b0;
            wait_done(2, 60);
            tick();
        end

        repeat (5) tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_stray_activity", d), stray[d], 0);
            chk($sformatf("d%0d_pending_frames", d), sbq[d].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
